// File: rtl/sobel_window_controller_if.sv
// Pixel-in / window-out handshake bundle for the Sobel window controller.
// The controller uses the slave modport; the pixel source / gradient side uses master.
interface sobel_window_controller_if;
  logic        frame_start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [71:0] window_flat;
  logic        start_calculations;
  logic        win_ready;
  logic        busy;
  logic        frame_done;

  modport master (
    output frame_start, pix_in, pix_valid, win_ready,
    input  pix_ready, window_flat, start_calculations, busy, frame_done
  );

  modport slave (
    input  frame_start, pix_in, pix_valid, win_ready,
    output pix_ready, window_flat, start_calculations, busy, frame_done
  );
endinterface

// File: rtl/sobel_window_controller.sv
// Two-row line buffer plus 3-column tap shifters that emit one 3x3 window per interior pixel.
// Optional macro SOBEL_ERR_EN adds a sticky err output for frame_start-while-busy and stray pix_valid.
module sobel_window_controller #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                      clk,
  input  logic                      reset,
  sobel_window_controller_if.slave  bus
`ifdef SOBEL_ERR_EN
  ,
  output logic                      err
`endif
);

  localparam int DATA_W = 8;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];

  logic [1:0][DATA_W-1:0] top_sh_p0, mid_sh_p0, bot_sh_p0;
  logic [DATA_W-1:0]      top_p0, mid_p0, bot_p0;

  logic [9*DATA_W-1:0] win_p1;
  logic                vld_p1;
  logic                done_p1;

  logic pix_ready_c;
  logic accept, handoff, emit, row_end;

  assign pix_ready_c = ((state == FILL) || (state == STREAM)) && (!vld_p1 || bus.win_ready);
  assign accept      = bus.pix_valid && pix_ready_c;
  assign handoff     = vld_p1 && bus.win_ready;
  assign row_end     = (col == COL_LAST);
  assign emit        = accept && (state == STREAM) && (col >= COL_TWO);

  // Stage p0: current-column taps (row r-2, row r-1, incoming row r)
  assign top_p0 = lb0[col];
  assign mid_p0 = lb1[col];
  assign bot_p0 = bus.pix_in;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.frame_start)                          state_nxt = FILL;
      FILL:    if (accept && row_end && (row == ROW_ONE))    state_nxt = STREAM;
      STREAM:  if (accept && row_end && (row == ROW_LAST))   state_nxt = DRAIN;
      DRAIN:   if (handoff)                                  state_nxt = IDLE;
      default:                                               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      vld_p1  <= 1'b0;
      win_p1  <= '0;
      done_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_p1 <= (state == DRAIN) && handoff;

      if ((state == IDLE) && bus.frame_start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (row_end) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // Stage p1: a fresh window wins over clearing the one being handed off
      if (emit) begin
        vld_p1 <= 1'b1;
        win_p1 <= {bot_p0, bot_sh_p0[0], bot_sh_p0[1],
                   mid_p0, mid_sh_p0[0], mid_sh_p0[1],
                   top_p0, top_sh_p0[0], top_sh_p0[1]};
      end else if (handoff) begin
        vld_p1 <= 1'b0;
        win_p1 <= '0;
      end
    end
  end

  // Line buffers and tap shifters are pure data: primed by the FILL rows, never reset.
  // Column 0 restarts the shifters so a window never straddles two rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= mid_p0;
      lb1[col] <= bot_p0;
      if (col == '0) begin
        top_sh_p0 <= {{DATA_W{1'b0}}, top_p0};
        mid_sh_p0 <= {{DATA_W{1'b0}}, mid_p0};
        bot_sh_p0 <= {{DATA_W{1'b0}}, bot_p0};
      end else begin
        top_sh_p0 <= {top_sh_p0[0], top_p0};
        mid_sh_p0 <= {mid_sh_p0[0], mid_p0};
        bot_sh_p0 <= {bot_sh_p0[0], bot_p0};
      end
    end
  end

`ifdef SOBEL_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((bus.frame_start && (state != IDLE)) ||
                 (bus.pix_valid && ((state == IDLE) || (state == DRAIN)))) begin
      err <= 1'b1;
    end
  end
`endif

  assign bus.pix_ready          = pix_ready_c;
  assign bus.window_flat        = win_p1;
  assign bus.start_calculations = vld_p1;
  assign bus.busy               = (state != IDLE);
  assign bus.frame_done         = done_p1;

endmodule

// File: tb/tb_sobel_window_controller.sv
// Scoreboard bench: a 4x4 instance for handshake/stall/reset/gap cases and a 5x3 instance for row wrap.
module tb_sobel_window_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_window_controller_if ifa ();
  sobel_window_controller_if ifb ();

`ifdef SOBEL_ERR_EN
  logic err_a, err_b;
`endif

  sobel_window_controller #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa.slave)
`ifdef SOBEL_ERR_EN
    , .err (err_a)
`endif
  );

  sobel_window_controller #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb.slave)
`ifdef SOBEL_ERR_EN
    , .err (err_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window centred at (r,c) of a frame whose pixel value equals its raster index
  function automatic logic [71:0] mk_win(input int w, input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'((r - 1 + k / 3) * w + (c - 1 + k % 3));
    return v;
  endfunction

  logic [71:0] expq_a[$];
  logic [71:0] expq_b[$];
  int n_win_a = 0, n_done_a = 0, acc_a = 0;
  int n_win_b = 0, n_done_b = 0;
  bit hold_a = 0, lat_due = 0, chk_fill_a = 0;
  logic [71:0] held_a;

  always @(negedge clk) begin
    if (rst) begin
      hold_a = 0;
    end else begin
      if (hold_a) begin
        check("hold_vld", 72'(ifa.start_calculations), 72'd1);
        check("hold_win", ifa.window_flat, held_a);
      end
      hold_a = ifa.start_calculations && !ifa.win_ready;
      held_a = ifa.window_flat;
      if (lat_due) begin
        lat_due = 0;
        check("lat_vld", 72'(ifa.start_calculations), 72'd1);
        check("lat_win", ifa.window_flat, mk_win(4, 1, 1));
      end
      if (chk_fill_a && acc_a < 11) check("fill_quiet", 72'(ifa.start_calculations), 72'd0);
      if (ifa.start_calculations && ifa.win_ready) begin
        n_win_a++;
        if (expq_a.size() == 0) check("sb_a_empty", 72'(expq_a.size()), 72'd1);
        else check("win_a", ifa.window_flat, expq_a.pop_front());
      end
      if (ifa.frame_done) n_done_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ifb.start_calculations && ifb.win_ready) begin
        n_win_b++;
        if (expq_b.size() == 0) check("sb_b_empty", 72'(expq_b.size()), 72'd1);
        else check("win_b", ifb.window_flat, expq_b.pop_front());
      end
      if (ifb.frame_done) n_done_b++;
    end
  end

  task automatic wait_acc_a(output bit ok);
    logic rdy;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      rdy = ifa.pix_ready;
      @(posedge clk);
      #1;
      ok = (rdy === 1'b1);
    end
    if (!ok) check("acc_timeout_a", 72'(ifa.pix_ready), 72'd1);
  endtask

  task automatic wait_acc_b(output bit ok);
    logic rdy;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      rdy = ifb.pix_ready;
      @(posedge clk);
      #1;
      ok = (rdy === 1'b1);
    end
    if (!ok) check("acc_timeout_b", 72'(ifb.pix_ready), 72'd1);
  endtask

  task automatic send_frame_a(input int gap, input bit stall, input bit fs_mid);
    bit ok;
    n_win_a = 0;
    n_done_a = 0;
    acc_a = 0;
    ifa.frame_start = 1;
    @(posedge clk);
    #1;
    ifa.frame_start = 0;
    for (int p = 0; p < 16; p++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        ifa.pix_valid = 0;
        @(posedge clk);
        #1;
      end
      ifa.pix_valid = 1;
      ifa.pix_in = 8'(p);
      if (fs_mid && p == 12) ifa.frame_start = 1;
      wait_acc_a(ok);
      ifa.frame_start = 0;
      if (!ok) break;
      acc_a = p + 1;
      if (p / 4 >= 2 && p % 4 >= 2) expq_a.push_back(mk_win(4, p / 4 - 1, p % 4 - 1));
      if (p == 10) lat_due = 1;
      if (stall && p == 10) begin
        ifa.win_ready = 0;
        ifa.pix_in = 8'(p + 1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_rdy", 72'(ifa.pix_ready), 72'd0);
          @(posedge clk);
          #1;
        end
        ifa.win_ready = 1;
      end
    end
    ifa.pix_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    check("n_win_a", 72'(n_win_a), 72'd4);
    check("n_done_a", 72'(n_done_a), 72'd1);
    check("sb_a_left", 72'(expq_a.size()), 72'd0);
    check("idle_a", 72'(ifa.busy), 72'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    ifa.frame_start = 0; ifa.pix_in = 0; ifa.pix_valid = 0; ifa.win_ready = 1;
    ifb.frame_start = 0; ifb.pix_in = 0; ifb.pix_valid = 0; ifb.win_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 72'(ifa.pix_ready), 72'd0);
    check("rst_start", 72'(ifa.start_calculations), 72'd0);
    check("rst_busy", 72'(ifa.busy), 72'd0);
    check("rst_done", 72'(ifa.frame_done), 72'd0);
    check("rst_win", ifa.window_flat, 72'd0);
    check("rst_busy_b", 72'(ifb.busy), 72'd0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;

    // Basic frame, then the same frame with a 5-cycle downstream stall
    send_frame_a(0, 0, 0);
    send_frame_a(0, 1, 0);

    // Reset one cycle after pixel 6, then a clean frame
    ifa.frame_start = 1;
    @(posedge clk);
    #1;
    ifa.frame_start = 0;
    for (int p = 0; p < 7; p++) begin
      ifa.pix_valid = 1;
      ifa.pix_in = 8'(p);
      wait_acc_a(ok);
    end
    ifa.pix_in = 8'd7;
    rst = 1;
    @(posedge clk);
    #1;
    ifa.pix_valid = 0;
    @(negedge clk);
    check("mid_rst_busy", 72'(ifa.busy), 72'd0);
    check("mid_rst_start", 72'(ifa.start_calculations), 72'd0);
    check("mid_rst_ready", 72'(ifa.pix_ready), 72'd0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    send_frame_a(0, 0, 0);

    // frame_start while streaming is ignored
    send_frame_a(0, 0, 1);
`ifdef SOBEL_ERR_EN
    check("err_sticky", 72'(err_a), 72'd1);
`endif

    // Random pix_valid gaps; no window may appear while the first rows fill
    chk_fill_a = 1;
    send_frame_a(30, 0, 0);
    chk_fill_a = 0;

    // 5x3 frame: three windows, all from the middle row
    ifb.frame_start = 1;
    @(posedge clk);
    #1;
    ifb.frame_start = 0;
    for (int p = 0; p < 15; p++) begin
      ifb.pix_valid = 1;
      ifb.pix_in = 8'(p);
      wait_acc_b(ok);
      if (!ok) break;
      if (p / 5 == 2 && p % 5 >= 2) expq_b.push_back(mk_win(5, 1, p % 5 - 1));
    end
    ifb.pix_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    check("n_win_b", 72'(n_win_b), 72'd3);
    check("n_done_b", 72'(n_done_b), 72'd1);
    check("sb_b_left", 72'(expq_b.size()), 72'd0);
    check("idle_b", 72'(ifb.busy), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
